reg_dump_sequencer: RTL

- Debug-side controller for the register file's debug read port.
- On a start command, or on the rising edge of pipeline halt, it walks the debug register address 0..NUM_REGS-1 and captures each 32-bit word.
- Each word is streamed as 4 bytes, MSB first, over a valid/ready byte interface toward the UART TX path.
- Holds o_freeze for the whole dump so no register-file write occurs while it is being read.

---
 rtl/reg_dump_if.sv | 22 ++
 rtl/reg_dump_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reg_dump_if.sv
// Debug register-read port plus the outgoing byte stream of the register dump sequencer.
// The master side is the sequencer; the slave side is the register file / UART TX consumer.
interface reg_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] o_du_reg_addr;
  logic [DATA_W-1:0] i_du_reg_data;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;

  modport master (
    output o_du_reg_addr, o_tx_data, o_tx_valid,
    input  i_du_reg_data, i_tx_ready
  );

  modport slave (
    input  o_du_reg_addr, o_tx_data, o_tx_valid,
    output i_du_reg_data, i_tx_ready
  );
endinterface

// File: rtl/reg_dump_sequencer.sv
// Walks debug register addresses 0..NUM_REGS-1 and streams each word MSB-first as bytes,
// freezing the pipeline for the duration. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module reg_dump_sequencer #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_halt,
  reg_dump_if.master bus,
  output logic       o_busy,
  output logic       o_freeze,
  output logic       o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SEND, S_DONE, S_CSUM} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SEND, S_DONE} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                halt_q, halt_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic       trig;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       done;

  // halt_q follows i_halt every cycle, so a rise seen while busy is consumed and lost.
  assign halt_d = i_halt;
  assign trig   = i_start | (i_halt & ~halt_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned
    // (which would infer a latch).
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          addr_d  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = S_LATCH;
        end
      end

      S_LATCH: begin
        shift_d    = bus.i_du_reg_data;
        byte_cnt_d = 2'd0;
        state_d    = S_SEND;
      end

      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[DATA_W-1 -: 8];
        if (bus.i_tx_ready) begin
          shift_d    = shift_q << 8;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d     = csum_q ^ tx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            if (addr_q == LAST_ADDR) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_LATCH;
            end
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (bus.i_tx_ready) state_d = S_DONE;
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      halt_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      halt_q     <= halt_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.o_du_reg_addr = addr_q;
  assign bus.o_tx_valid    = tx_valid;
  assign bus.o_tx_data     = tx_data;
  assign o_busy            = (state_q != S_IDLE);
  assign o_freeze          = o_busy;
  assign o_done            = done;

endmodule
